// File: rtl/deserializer_sipo_if.sv
// Serial receive and parallel word handshake bundle for deserializer_sipo.
// The master drives the serial line and the consumer ready; the slave is the receiver.
interface deserializer_sipo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  srl_in;
    logic                  srl_valid;
    logic                  srl_start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  rx_busy;
    logic                  frame_err;
    logic                  overrun;

    modport master (
        output srl_in, srl_valid, srl_start, data_ready,
        input  data_out, data_valid, rx_busy, frame_err, overrun
    );

    modport slave (
        input  srl_in, srl_valid, srl_start, data_ready,
        output data_out, data_valid, rx_busy, frame_err, overrun
    );
endinterface

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: assembles LSB-first words aligned by a start marker
// and presents them on a valid/ready port, flagging framing errors and overruns.
module deserializer_sipo #(
    parameter int DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    deserializer_sipo_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sh, sh_nxt;
    logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  complete;
    logic                  frame_err_nxt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] first_bit;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, ferr_q, over_q;

    // Right shift parks the first bit at bit 0 once the word is complete.
    assign shifted   = {bus.srl_in, sh[DATA_WIDTH-1:1]};
    assign first_bit = {bus.srl_in, {(DATA_WIDTH-1){1'b0}}};

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        bit_cnt_nxt   = bit_cnt;
        complete      = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.srl_valid && bus.srl_start) begin
                    state_nxt   = SHIFT;
                    sh_nxt      = first_bit;
                    bit_cnt_nxt = CW'(1);
                end
            end
            SHIFT: begin
                if (bus.srl_valid) begin
                    if (bus.srl_start) begin
                        frame_err_nxt = 1'b1;
                        sh_nxt        = first_bit;
                        bit_cnt_nxt   = CW'(1);
                    end else begin
                        sh_nxt = shifted;
                        if (bit_cnt == LAST_BIT) begin
                            complete    = 1'b1;
                            state_nxt   = IDLE;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sh      <= sh_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // A completed word only lands when the output slot is free or being drained this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            ferr_q <= frame_err_nxt;
            if (complete) begin
                if (!valid_q || bus.data_ready) begin
                    data_q  <= shifted;
                    valid_q <= 1'b1;
                end else begin
                    over_q <= 1'b1;
                end
            end else if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = over_q;
    assign bus.rx_busy    = (state == SHIFT);
endmodule
